// File: rtl/multiphase_clock_gen.sv
`default_nettype none
// ============================================================================
// Module   : multiphase_clock_gen
// Brief    : N-phase one-hot instruction clock with halt/run/step modes,
//            debounced step key, centre-out LED bar and retired-cycle counter.
//            Optional mid-cycle phase break enabled by PHASE_BREAK_EN.
// Revision : 1.0
// ============================================================================
module multiphase_clock_gen #(
    parameter int PHASES          = 6,
    parameter int DIV_W           = 25,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LED_W           = 10,
    parameter int CNT_W           = 8,
    localparam int IDX_W          = (PHASES > 1) ? $clog2(PHASES) : 1
) (
    input  logic               CLOCK_50,
    input  logic               SysReset,
    input  logic               run,
    input  logic               step_n,
    input  logic [DIV_W-1:0]   div_val,
`ifdef PHASE_BREAK_EN
    input  logic               brk_en,
    input  logic [IDX_W-1:0]   brk_phase,
`endif
    output logic [PHASES-1:0]  Phases,
    output logic [IDX_W-1:0]   phase_idx,
    output logic               cycle_done,
    output logic [CNT_W-1:0]   cycle_count,
    output logic               halted,
    output logic [LED_W-1:0]   leds
);

    localparam int               c_db_w     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int               c_half     = LED_W / 2;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(PHASES - 1);
    localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_db_level;
    logic [c_db_w-1:0]  r_db_cnt;
    logic               r_step_req;
    state_t             r_state;
    logic               r_halted;
    logic [DIV_W-1:0]   r_count;
    logic [PHASES-1:0]  r_phases;
    logic [IDX_W-1:0]   r_idx;
    logic               r_done;
    logic [CNT_W-1:0]   r_cyc_cnt;
    logic [LED_W-1:0]   r_leds;

    logic               w_active;
    logic               w_tick;
    logic               w_wrap;
    logic               w_brk;
    logic [IDX_W-1:0]   w_idx_next;
    state_t             w_next_state;
    logic [LED_W-1:0]   w_leds_next;

    always_comb begin
        w_active   = (r_state == S_RUN) || (r_state == S_STEP);
        w_tick     = w_active && (r_count >= div_val);
        w_idx_next = (r_idx == c_last_idx) ? '0 : r_idx + IDX_W'(1);
        w_wrap     = w_tick && (r_idx == c_last_idx);
`ifdef PHASE_BREAK_EN
        w_brk      = w_tick && brk_en && (w_idx_next == brk_phase);
`else
        w_brk      = 1'b0;
`endif

        w_next_state = r_state;
        case (r_state)
            S_HALT: begin
                if (run)
                    w_next_state = S_RUN;
                else if (r_step_req)
                    w_next_state = S_STEP;
            end
            // Run only stops at a cycle boundary unless a break point hits.
            S_RUN: begin
                if ((w_wrap && !run) || w_brk)
                    w_next_state = S_HALT;
            end
            S_STEP: begin
                if (w_wrap)
                    w_next_state = run ? S_RUN : S_HALT;
            end
            default: w_next_state = S_HALT;
        endcase

        // Bar lights symmetrically from the centre outwards as the phase grows.
        w_leds_next = '0;
        for (int i = 0; i < c_half; i++) begin
            w_leds_next[i]           = (int'(w_idx_next) >= c_half - i);
            w_leds_next[LED_W-1-i]   = (int'(w_idx_next) >= c_half - i);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge SysReset) begin
        if (SysReset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_db_level <= 1'b1;
            r_db_cnt   <= '0;
            r_step_req <= 1'b0;
            r_state    <= S_HALT;
            r_halted   <= 1'b1;
            r_count    <= '0;
            r_phases   <= PHASES'(1);
            r_idx      <= '0;
            r_done     <= 1'b0;
            r_cyc_cnt  <= '0;
            r_leds     <= '0;
        end else begin
            r_sync1    <= step_n;
            r_sync2    <= r_sync1;
            r_step_req <= 1'b0;
            if (r_sync2 != r_db_level) begin
                if (r_db_cnt == c_db_last) begin
                    r_db_level <= r_sync2;
                    r_db_cnt   <= '0;
                    r_step_req <= r_db_level;
                end else begin
                    r_db_cnt   <= r_db_cnt + c_db_w'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end

            r_state  <= w_next_state;
            r_halted <= (w_next_state == S_HALT);
            r_done   <= w_wrap;

            // Held at zero while halted, so every entry into RUN/STEP starts clean.
            if (!w_active || w_tick)
                r_count <= '0;
            else
                r_count <= r_count + DIV_W'(1);

            if (w_tick) begin
                r_idx    <= w_idx_next;
                r_phases <= {r_phases[PHASES-2:0], r_phases[PHASES-1]};
                r_leds   <= w_leds_next;
            end

            if (w_wrap)
                r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
        end
    end

    assign Phases      = r_phases;
    assign phase_idx   = r_idx;
    assign cycle_done  = r_done;
    assign cycle_count = r_cyc_cnt;
    assign halted      = r_halted;
    assign leds        = r_leds;

endmodule
`default_nettype wire
